car_spawner: RTL

CAR_SPAWNER -- requirements
Module: car_spawner

---
 rtl/road_pkg.sv | 54 +++++
 rtl/lfsr16.sv | 24 ++
 rtl/car_spawner.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/road_pkg.sv
// Road geometry, car type encodings and spawner FSM state type shared by the traffic blocks.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package road_pkg;

    // Car type encoding carried on the per-slot cartype fields
    localparam logic [1:0] CAR_YELLOW = 2'd0;
    localparam logic [1:0] CAR_RED    = 2'd1;
    localparam logic [1:0] CAR_TRUCK  = 2'd2;

    // Road geometry in pixels
    localparam int ROAD_LEFT  = 215;
    localparam int ROAD_RIGHT = 399;
    localparam int LANE_PITCH = 36;
    localparam int LANE_COUNT = 5;
    localparam int CAR_WIDTH  = 32;

    // last_lane value meaning "no car accepted yet"; never equals a real lane
    localparam logic [2:0] LANE_NONE = 3'd7;

    // Spawn randomness source
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        PICK    = 2'd2,
        RELEASE = 2'd3
    } spawn_state_t;

    // Fold 3 random bits onto the 5 lanes (5,6,7 -> 0,1,2), then step one
    // lane to the right (wrapping) so two consecutive cars never share a lane.
    function automatic logic [2:0] pick_lane(input logic [2:0] raw, input logic [2:0] last);
        logic [2:0] l;
        l = (raw >= 3'(LANE_COUNT)) ? raw - 3'(LANE_COUNT) : raw;
        if (l == last) begin
            l = (l == 3'(LANE_COUNT - 1)) ? 3'd0 : l + 3'd1;
        end
        return l;
    endfunction

    // Left edge of a car in the given lane. The clamp only matters for an
    // out-of-range lane and keeps the car's right edge inside the border.
    function automatic logic [10:0] lane_x(input logic [2:0] lane);
        int x;
        x = ROAD_LEFT + LANE_PITCH * int'(lane);
        if (x + CAR_WIDTH > ROAD_RIGHT) begin
            x = ROAD_RIGHT - CAR_WIDTH;
        end
        return 11'(x);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (mask 0xB400) free-running every clock; feeds spawn lane/type choice.
// Latency: new value every clk; reset loads the seed asynchronously.
// Backpressure: none, never stalls.
//
// Ports: clk, resetN (async active-low), state[15:0] current register value.
module lfsr16
    import road_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    output logic [15:0] state
);

    // Right-shifting Galois form: the bit shifted out folds back through the mask.
    // A non-zero seed with a maximal-length mask never reaches the all-zero lockup.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= LFSR_SEED;
        end else begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/car_spawner.sv
// Traffic car spawner: every SPAWN_PERIOD onesec pulses, hands a random car (lane, type) to an idle mover slot.
// Latency: release request two clks after the triggering onesec when a slot is ready; all outputs registered.
// Backpressure: waits in PICK while no slot is ready; holds the release until the mover drops ready or the frame timeout expires.
//
// Ports:
//   clk, resetN         single clock, asynchronous active-low reset
//   startOfFrame        one-clk pulse per video frame (release timeout base)
//   onesec              one-clk pulse per second (spawn period base)
//   enable              game running; low halts spawning and returns to IDLE
//   ready[N]            per-slot mover idle flag
//   releasecar[N]       per-slot release request, one-hot or zero
//   cartype[2N]         per-slot car type, slot i in [2i+1:2i]
//   carXinitial[11N]    per-slot spawn X in pixels, slot i in [11i+10:11i]
//
// Build option: define CAR_SPAWNER_TRUCK_EN to emit trucks (type 2); otherwise
// a decoded truck is downgraded to a red car.
module car_spawner
    import road_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int SPAWN_PERIOD    = 2,
    parameter int RELEASE_TIMEOUT = 3
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    onesec,
    input  logic                    enable,
    input  logic [NUM_SLOTS-1:0]    ready,
    output logic [NUM_SLOTS-1:0]    releasecar,
    output logic [2*NUM_SLOTS-1:0]  cartype,
    output logic [11*NUM_SLOTS-1:0] carXinitial
);

    localparam int              PW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int              TW         = $clog2(RELEASE_TIMEOUT + 1);
    localparam logic [PW-1:0]   LAST_SLOT  = PW'(NUM_SLOTS - 1);
    localparam logic [PW:0]     SLOT_COUNT = (PW+1)'(NUM_SLOTS);
    localparam logic [3:0]      TICK_LAST  = 4'(SPAWN_PERIOD - 1);
    localparam logic [TW-1:0]   TO_LAST    = TW'(RELEASE_TIMEOUT - 1);
    localparam logic [10:0]     X_RESET    = 11'(ROAD_LEFT);

    spawn_state_t state, state_nxt;

    logic [15:0]            lfsr;
    logic                   lfsr_unused;

    logic [3:0]             tick_cnt;
    logic [TW-1:0]          to_cnt;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          sel;
    logic [2:0]             lane;
    logic [2:0]             last_lane;

    logic [2*NUM_SLOTS-1:0] ready_rot;
    logic                   pick_hit;
    logic [PW-1:0]          pick_off;
    logic [PW:0]            pick_sum;
    logic [PW-1:0]          pick_slot;
    logic [PW-1:0]          rr_after_sel;
    logic [2:0]             lane_new;
    logic [1:0]             type_new;
    logic                   count_done;
    logic                   accept;
    logic                   timeout;

    lfsr16 u_lfsr (
        .clk    (clk),
        .resetN (resetN),
        .state  (lfsr)
    );

    // Only the low five bits pick lane and type.
    assign lfsr_unused = ^lfsr[15:5];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state; enable low overrides everything
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = COUNT;
                COUNT:   if (count_done)        state_nxt = PICK;
                PICK:    if (pick_hit)          state_nxt = RELEASE;
                RELEASE: if (accept || timeout) state_nxt = COUNT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM output decode: slot search, car choice, handshake conditions
    // ------------------------------------------------------------------
    always_comb begin
        // Rotate ready so bit 0 is the slot at rr_ptr; the lowest set bit of
        // the rotated vector is then the round-robin winner.
        ready_rot = {ready, ready} >> rr_ptr;
        pick_hit  = 1'b0;
        pick_off  = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (ready_rot[k]) begin
                pick_hit = 1'b1;
                pick_off = PW'(k);
            end
        end
        pick_sum  = {1'b0, rr_ptr} + {1'b0, pick_off};
        pick_slot = (pick_sum >= SLOT_COUNT) ? PW'(pick_sum - SLOT_COUNT) : PW'(pick_sum);

        rr_after_sel = (sel == LAST_SLOT) ? '0 : sel + 1'b1;

        lane_new = pick_lane(lfsr[2:0], last_lane);
        type_new = (lfsr[4:3] == 2'd3) ? CAR_YELLOW : lfsr[4:3];
`ifndef CAR_SPAWNER_TRUCK_EN
        if (type_new == CAR_TRUCK) begin
            type_new = CAR_RED;
        end
`endif

        count_done = onesec && (tick_cnt == TICK_LAST);
        // The mover signals it took the car by dropping its ready flag.
        accept     = !ready[sel];
        timeout    = startOfFrame && (to_cnt == TO_LAST);
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tick_cnt    <= '0;
            to_cnt      <= '0;
            rr_ptr      <= '0;
            sel         <= '0;
            lane        <= '0;
            last_lane   <= LANE_NONE;
            releasecar  <= '0;
            cartype     <= '0;
            carXinitial <= {NUM_SLOTS{X_RESET}};
        end else if (!enable) begin
            // Halt: drop any pending release and restart counting from zero;
            // the per-slot car descriptions are left as they were.
            releasecar <= '0;
            tick_cnt   <= '0;
            to_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    to_cnt   <= '0;
                end
                COUNT: begin
                    if (onesec) begin
                        tick_cnt <= count_done ? 4'd0 : tick_cnt + 4'd1;
                    end
                end
                PICK: begin
                    // No ready slot: nothing changes, search again next clk.
                    if (pick_hit) begin
                        sel        <= pick_slot;
                        lane       <= lane_new;
                        to_cnt     <= '0;
                        releasecar <= NUM_SLOTS'(1) << pick_slot;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (pick_slot == PW'(i)) begin
                                cartype[2*i +: 2]       <= type_new;
                                carXinitial[11*i +: 11] <= lane_x(lane_new);
                            end
                        end
                    end
                end
                RELEASE: begin
                    if (accept) begin
                        releasecar <= '0;
                        last_lane  <= lane;
                        rr_ptr     <= rr_after_sel;
                        to_cnt     <= '0;
                    end else if (timeout) begin
                        // Abandoned car: move on to the next slot, but the lane
                        // was never used so last_lane keeps its old value.
                        releasecar <= '0;
                        rr_ptr     <= rr_after_sel;
                        to_cnt     <= '0;
                    end else if (startOfFrame) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    releasecar <= '0;
                end
            endcase
        end
    end

endmodule
